// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type and frame geometry.
// Kept separate so the receiver can reuse the same encodings.
package uart_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      TRANSMIT = 1'b1
   } uart_state_e;

   // start + 8 data + stop
   localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_if.sv
// Transmit-side handshake bundle: request/data from the client, line and status back.
interface uart_tx_if;

   logic       trmt;
   logic [7:0] tx_data;
   logic       TX;
   logic       tx_done;
   logic       busy;

   modport master (
      output trmt, tx_data,
      input  TX, tx_done, busy
   );

   modport slave (
      input  trmt, tx_data,
      output TX, tx_done, busy
   );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled and flags the terminal
// count so the owner can advance one bit. Shared by transmit and receive paths.
module uart_baud_cnt #(
   parameter int BAUD_DIV = 2604
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic shift
);

   localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

   logic [CNT_W-1:0] cnt;

   // Terminal count is only meaningful while the timer is running.
   assign shift = en && (cnt == LAST);

   // Count up while enabled, wrap at terminal count; clr takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1. A start request loads a 10-bit frame into a shift
// register whose bit 0 drives the line; every output comes straight off a flop.
module uart_tx
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = 2604
) (
   input  logic      clk,
   input  logic      rst_n,
   uart_tx_if.slave  bus
);

   localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

   uart_state_e             state_q, state_d;
   logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
   logic [3:0]              bit_cnt_q, bit_cnt_d;
   logic                    done_q, done_d;
   logic                    baud_clr, baud_en, shift;

   // Timer is held at zero in IDLE so the first bit gets a full period.
   assign baud_en = (state_q == TRANSMIT);

   uart_baud_cnt #(.BAUD_DIV(BAUD_DIV)) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (baud_clr),
      .en    (baud_en),
      .shift (shift)
   );

   // State and datapath registers; reset leaves the line idling high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shreg_q   <= '1;
         bit_cnt_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         done_q    <= done_d;
      end
   end

   // Next-state: accept trmt only in IDLE; shift out on each baud terminal
   // count and return to IDLE when the stop bit has been fully sent.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = done_q;
      baud_clr  = 1'b0;
      case (state_q)
         IDLE: begin
            baud_clr = 1'b1;
            if (bus.trmt) begin
               state_d   = TRANSMIT;
               shreg_d   = {1'b1, bus.tx_data, 1'b0};
               bit_cnt_d = '0;
               done_d    = 1'b0;
            end
         end
         TRANSMIT: begin
            if (shift) begin
               shreg_d   = {1'b1, shreg_q[FRAME_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.TX      = shreg_q[0];
   assign bus.tx_done = done_q;
   assign bus.busy    = (state_q == TRANSMIT);

endmodule
